// File: rtl/rw_mem_arbiter.sv
// Round-robin two-port arbiter/sequencer for the 96x8 RW data memory window.
// Hides the registered-read latency and parks the memory address when idle.
module rw_mem_arbiter #(
   parameter int unsigned BASE = 128,
   parameter int unsigned SIZE = 96,
   parameter int unsigned PARK = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       a_req,
   input  logic       a_we,
   input  logic [7:0] a_addr,
   input  logic [7:0] a_wdata,
   output logic       a_gnt,
   output logic       a_rvalid,
   output logic       a_err,
   input  logic       b_req,
   input  logic       b_we,
   input  logic [7:0] b_addr,
   input  logic [7:0] b_wdata,
   output logic       b_gnt,
   output logic       b_rvalid,
   output logic       b_err,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       mem_write,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata
);

   localparam logic [7:0] ParkAddr = 8'(PARK);

   typedef enum logic [1:0] {StIdle, StAccess, StRdata} state_e;

   state_e     state_q, state_d;
   logic       last_q, last_d;     // 0 = A, 1 = B
   logic       owner_q, owner_d;
   logic       rd_q, rd_d;
   logic       a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
   logic       a_err_q, a_err_d, b_err_q, b_err_d;
   logic       a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
   logic [7:0] rdata_q, rdata_d;
   logic       mem_write_q, mem_write_d;
   logic [7:0] mem_addr_q, mem_addr_d;
   logic [7:0] mem_wdata_q, mem_wdata_d;

   logic       pick_b;
   logic       sel_we;
   logic [7:0] sel_addr;
   logic [7:0] sel_wdata;
   logic       sel_in_win;

   // B wins when it is alone, or on a tie when A was served last.
   assign pick_b     = b_req && (!a_req || !last_q);
   assign sel_we     = pick_b ? b_we    : a_we;
   assign sel_addr   = pick_b ? b_addr  : a_addr;
   assign sel_wdata  = pick_b ? b_wdata : a_wdata;
   assign sel_in_win = (32'(sel_addr) >= BASE) && (32'(sel_addr) <= BASE + SIZE - 1);

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      rd_d        = rd_q;
      a_gnt_d     = 1'b0;
      b_gnt_d     = 1'b0;
      a_err_d     = 1'b0;
      b_err_d     = 1'b0;
      a_rvalid_d  = 1'b0;
      b_rvalid_d  = 1'b0;
      rdata_d     = rdata_q;
      mem_write_d = 1'b0;
      mem_addr_d  = ParkAddr;
      mem_wdata_d = mem_wdata_q;
      unique case (state_q)
         StIdle: begin
            if (a_req || b_req) begin
               last_d  = pick_b;
               a_gnt_d = !pick_b;
               b_gnt_d = pick_b;
               if (sel_in_win) begin
                  mem_addr_d  = sel_addr;
                  mem_wdata_d = sel_wdata;
                  mem_write_d = sel_we;
                  owner_d     = pick_b;
                  rd_d        = !sel_we;
                  state_d     = StAccess;
               end else begin
                  a_err_d = !pick_b;
                  b_err_d = pick_b;
               end
            end
         end
         StAccess: state_d = rd_q ? StRdata : StIdle;
         StRdata: begin
            rdata_d    = mem_rdata;
            a_rvalid_d = !owner_q;
            b_rvalid_d = owner_q;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         rd_q        <= 1'b0;
         a_gnt_q     <= 1'b0;
         b_gnt_q     <= 1'b0;
         a_err_q     <= 1'b0;
         b_err_q     <= 1'b0;
         a_rvalid_q  <= 1'b0;
         b_rvalid_q  <= 1'b0;
         rdata_q     <= 8'h00;
         mem_write_q <= 1'b0;
         mem_addr_q  <= ParkAddr;
         mem_wdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         rd_q        <= rd_d;
         a_gnt_q     <= a_gnt_d;
         b_gnt_q     <= b_gnt_d;
         a_err_q     <= a_err_d;
         b_err_q     <= b_err_d;
         a_rvalid_q  <= a_rvalid_d;
         b_rvalid_q  <= b_rvalid_d;
         rdata_q     <= rdata_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign a_gnt     = a_gnt_q;
   assign b_gnt     = b_gnt_q;
   assign a_err     = a_err_q;
   assign b_err     = b_err_q;
   assign a_rvalid  = a_rvalid_q;
   assign b_rvalid  = b_rvalid_q;
   assign rdata     = rdata_q;
   assign busy      = (state_q != StIdle);
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_rw_mem_arbiter.sv
// Scoreboard bench for rw_mem_arbiter: drivers push expectations, a monitor pops and compares.
module tb_rw_mem_arbiter;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [7:0] a_addr = 8'h00, a_wdata = 8'h00, b_addr = 8'h00, b_wdata = 8'h00;
   logic       a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
   logic [7:0] rdata, mem_addr, mem_wdata;
   logic       busy, mem_write;
   logic [7:0] mem_rdata = 8'h00;

   always #5 clk = ~clk;

   rw_mem_arbiter #(.BASE(128), .SIZE(96), .PARK(0)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_err(a_err),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_err(b_err),
      .rdata(rdata), .busy(busy), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Memory model: synchronous write, registered read.
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   initial for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   typedef struct packed {
      logic       err;
      logic       rd;
      logic [7:0] data;
   } exp_t;

   exp_t       a_exp[$], b_exp[$];
   logic [7:0] a_rd_q[$], b_rd_q[$];
   bit         gnt_log[$];
   int         n_tests = 0, n_fail = 0;
   int         a_issued = 0, b_issued = 0, a_gnts = 0, b_gnts = 0;
   exp_t       mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit in_win(input logic [7:0] a);
      return (a >= 8'h80) && (a <= 8'hDF);
   endfunction

   // Caller must be away from the clock edge; returns #1 after the granting edge.
   task automatic issue(input bit port, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata);
      exp_t e;
      bit   got;
      e.err  = !in_win(addr);
      e.rd   = !we;
      e.data = ref_mem[addr];
      if (we && in_win(addr)) ref_mem[addr] = wdata;
      if (!port) begin
         a_exp.push_back(e); a_issued++;
         a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
      end else begin
         b_exp.push_back(e); b_issued++;
         b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
      end
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge clk); #1;
         got = port ? b_gnt : a_gnt;
      end
      if (!port) a_req = 1'b0; else b_req = 1'b0;
      if (!got) begin
         n_tests++; n_fail++;
         $display("FAIL gnt_timeout port=%0d: got no gnt, expected one", port);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (reset_n) begin
         if (a_gnt && b_gnt) check("gnt_both", 1, 0);
         if (a_gnt) begin
            a_gnts++; gnt_log.push_back(1'b0);
            if (a_exp.size() == 0) check("a_gnt_unexpected", 1, 0);
            else begin
               mon_e = a_exp.pop_front();
               check("a_err", a_err, mon_e.err);
               if (!mon_e.err && mon_e.rd) a_rd_q.push_back(mon_e.data);
            end
         end else if (a_err) check("a_err_without_gnt", 1, 0);
         if (b_gnt) begin
            b_gnts++; gnt_log.push_back(1'b1);
            if (b_exp.size() == 0) check("b_gnt_unexpected", 1, 0);
            else begin
               mon_e = b_exp.pop_front();
               check("b_err", b_err, mon_e.err);
               if (!mon_e.err && mon_e.rd) b_rd_q.push_back(mon_e.data);
            end
         end else if (b_err) check("b_err_without_gnt", 1, 0);
         if (a_rvalid) begin
            if (a_rd_q.size() == 0) check("a_rvalid_unexpected", 1, 0);
            else check("a_rdata", rdata, a_rd_q.pop_front());
         end
         if (b_rvalid) begin
            if (b_rd_q.size() == 0) check("b_rvalid_unexpected", 1, 0);
            else check("b_rdata", rdata, b_rd_q.pop_front());
         end
         if (mem_write) check("mem_write_in_window", in_win(mem_addr), 1);
         if (!busy) check("idle_parked", {mem_write, mem_addr}, 9'h000);
      end
   end

   task automatic rand_port(input bit port, input int n);
      logic [7:0] addr;
      repeat (n) begin
         cycles($urandom_range(0, 2));
         if ($urandom_range(0, 7) == 0)
            addr = $urandom_range(0, 1) ? 8'h7F - 8'($urandom_range(0, 15))
                                        : 8'hE0 + 8'($urandom_range(0, 31));
         else
            addr = (port ? 8'hB0 : 8'h80) + 8'($urandom_range(0, 47));
         issue(port, 1'($urandom_range(0, 1)), addr, 8'($urandom_range(0, 255)));
      end
   endtask

   initial begin
      // Reset state
      #2;
      check("reset_outputs", {a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, rdata, busy,
                              mem_write, mem_addr, mem_wdata}, 0);
      @(negedge clk); reset_n = 1'b1;
      cycles(2);

      // Test 1: A write then read with latency checks
      issue(0, 1, 8'h80, 8'h5A);
      check("t1_mem_write_on", mem_write, 1);
      check("t1_mem_addr", mem_addr, 8'h80);
      check("t1_mem_wdata", mem_wdata, 8'h5A);
      cycles(1);
      check("t1_mem_write_off", mem_write, 0);
      check("t1_mem_parked", mem_addr, 8'h00);
      cycles(1);
      issue(0, 0, 8'h80, 8'h00);
      cycles(1);
      check("t1_rvalid_e1", a_rvalid, 0);
      cycles(1);
      check("t1_rvalid_e2", a_rvalid, 1);
      check("t1_rdata", rdata, 8'h5A);
      cycles(1);
      check("t1_rvalid_e3", a_rvalid, 0);

      // Test 3: top-of-window B access, then out-of-window writes
      issue(1, 1, 8'hDF, 8'h11);
      cycles(1);
      issue(1, 0, 8'hDF, 8'h00);
      cycles(3);
      check("t3_rdata_df", rdata, 8'h11);
      issue(1, 1, 8'hE0, 8'h22);
      check("t3_b_err_e0", b_err, 1);
      check("t3_parked_e0", {mem_write, mem_addr}, 9'h000);
      cycles(1);
      issue(0, 1, 8'h7F, 8'h33);
      check("t3_a_err_7f", a_err, 1);
      check("t3_parked_7f", {mem_write, mem_addr}, 9'h000);
      cycles(2);

      // Test 4: out-of-window read leaves rdata untouched
      issue(0, 1, 8'h85, 8'h33);
      cycles(1);
      issue(0, 0, 8'h85, 8'h00);
      cycles(3);
      check("t4_rdata", rdata, 8'h33);
      issue(1, 0, 8'h10, 8'h00);
      check("t4_b_err", b_err, 1);
      cycles(4);
      check("t4_rdata_held", rdata, 8'h33);

      // Test 2: both ports request reads from reset; grants must alternate
      gnt_log.delete();
      reset_n = 1'b0;
      fork
         repeat (4) issue(0, 0, 8'h80, 8'h00);
         repeat (4) issue(1, 0, 8'hDF, 8'h00);
         begin cycles(2); @(negedge clk); reset_n = 1'b1; end
      join
      cycles(4);
      check("t2_gnt_count", gnt_log.size(), 8);
      for (int i = 0; i < gnt_log.size(); i++) check("t2_gnt_order", gnt_log[i], i % 2);

      // Test 5: reset during the ACCESS cycle of a write aborts it
      issue(0, 1, 8'h90, 8'h00);
      cycles(2);
      a_we = 1'b1; a_addr = 8'h90; a_wdata = 8'hFF; a_req = 1'b1;
      for (int i = 0; i < 20 && !a_gnt; i++) begin @(posedge clk); #1; end
      a_req = 1'b0;
      check("t5_in_access", {busy, mem_write}, 2'b11);
      reset_n = 1'b0;
      #1;
      check("t5_abort_mem_write", mem_write, 0);
      check("t5_abort_mem_addr", mem_addr, 8'h00);
      check("t5_abort_busy", busy, 0);
      cycles(2);
      check("t5_mem_untouched", mem[8'h90], 8'h00);
      @(negedge clk); reset_n = 1'b1;
      cycles(1);
      issue(0, 0, 8'h90, 8'h00);
      cycles(3);
      check("t5_read_back", rdata, 8'h00);

      // Test 6: random traffic on both ports, disjoint address halves
      fork
         rand_port(0, 300);
         rand_port(1, 300);
      join
      cycles(6);
      check("end_a_exp_empty", a_exp.size(), 0);
      check("end_b_exp_empty", b_exp.size(), 0);
      check("end_a_rd_empty", a_rd_q.size(), 0);
      check("end_b_rd_empty", b_rd_q.size(), 0);
      check("end_a_gnt_per_req", a_gnts, a_issued);
      check("end_b_gnt_per_req", b_gnts, b_issued);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
